// File: rtl/crosscorr_pkg.sv
// crosscorr_pkg: shared widths, sequencer state encoding and operand/result types
package crosscorr_pkg;
   localparam int W_IN = 25;
   localparam int W_OUT = 2 * W_IN + 1;
   typedef enum logic [2:0] {IDLE = 3'd0, M0 = 3'd1, M1 = 3'd2, M2 = 3'd3, M3 = 3'd4, OUT = 3'd5} state_t;
   typedef logic signed [W_IN-1:0] opnd_t;
   typedef logic signed [2*W_IN-1:0] prod_t;
   typedef logic signed [W_OUT-1:0] res_t;
endpackage

// File: rtl/crosscorr_shared_mul.sv
// crosscorr_shared_mul: combinational signed W x W -> 2W multiplier shared across the sequence
module crosscorr_shared_mul #(
   parameter int W = 25
) (
   input  logic signed [W-1:0]   x,
   input  logic signed [W-1:0]   y,
   output logic signed [2*W-1:0] p
);
   assign p = x * y;
endmodule

// File: rtl/crosscorr_cmul_seq.sv
// crosscorr_cmul_seq: complex product a*conj(b) (or a*b) built from four real multiplies on one
// shared multiplier, with valid/ready handshakes on both sides
module crosscorr_cmul_seq #(
   parameter int W_IN = crosscorr_pkg::W_IN,
   parameter int W_OUT = crosscorr_pkg::W_OUT,
   parameter bit CONJ_B = 1'b1
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [W_IN-1:0]  a_re,
   input  logic signed [W_IN-1:0]  a_im,
   input  logic signed [W_IN-1:0]  b_re,
   input  logic signed [W_IN-1:0]  b_im,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [W_OUT-1:0] out_re,
   output logic signed [W_OUT-1:0] out_im,
   output logic [15:0]             op_count
);
   crosscorr_pkg::state_t state_q, state_d;
   logic signed [W_IN-1:0] a_re_q, a_re_d, a_im_q, a_im_d, b_re_q, b_re_d, b_im_q, b_im_d;
   logic signed [W_OUT-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
   logic out_valid_q, out_valid_d;
   logic [15:0] cnt_q, cnt_d;
   logic signed [W_IN-1:0] mx, my;
   logic signed [2*W_IN-1:0] prod;
   logic signed [W_OUT-1:0] pext;
   logic take, done;
   logic in_m1, in_m2, in_m3;

   assign in_m1 = state_q == crosscorr_pkg::M1;
   assign in_m2 = state_q == crosscorr_pkg::M2;
   assign in_m3 = state_q == crosscorr_pkg::M3;
   assign in_ready = state_q == crosscorr_pkg::IDLE || (state_q == crosscorr_pkg::OUT && out_ready);
   assign take = in_valid && in_ready;
   assign done = out_valid_q && out_ready;

   // Outside M1..M3 the select rests on the M0 pair so the multiplier inputs stay quiet
   assign mx = in_m1 || in_m2 ? a_im_q : a_re_q;
   assign my = in_m1 || in_m3 ? b_im_q : b_re_q;

   crosscorr_shared_mul #(.W(W_IN)) u_mul (.x(mx), .y(my), .p(prod));

   assign pext = W_OUT'(prod);

   always_comb begin
      state_d = state_q;
      case (state_q)
         crosscorr_pkg::IDLE: state_d = take ? crosscorr_pkg::M0 : crosscorr_pkg::IDLE;
         crosscorr_pkg::M0:   state_d = crosscorr_pkg::M1;
         crosscorr_pkg::M1:   state_d = crosscorr_pkg::M2;
         crosscorr_pkg::M2:   state_d = crosscorr_pkg::M3;
         crosscorr_pkg::M3:   state_d = crosscorr_pkg::OUT;
         crosscorr_pkg::OUT:  state_d = !out_ready ? crosscorr_pkg::OUT : in_valid ? crosscorr_pkg::M0 : crosscorr_pkg::IDLE;
         default:             state_d = crosscorr_pkg::IDLE;
      endcase
   end

   always_comb begin
      a_re_d = take ? a_re : a_re_q;
      a_im_d = take ? a_im : a_im_q;
      b_re_d = take ? b_re : b_re_q;
      b_im_d = take ? b_im : b_im_q;
      acc_re_d = state_q == crosscorr_pkg::M0 ? pext :
                 in_m1 ? (CONJ_B ? acc_re_q + pext : acc_re_q - pext) : acc_re_q;
      acc_im_d = in_m2 ? pext :
                 in_m3 ? (CONJ_B ? acc_im_q - pext : acc_im_q + pext) : acc_im_q;
      out_valid_d = state_d == crosscorr_pkg::OUT;
      cnt_d = cnt_q + 16'(done);
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state_q <= crosscorr_pkg::IDLE;
         a_re_q <= '0;
         a_im_q <= '0;
         b_re_q <= '0;
         b_im_q <= '0;
         acc_re_q <= '0;
         acc_im_q <= '0;
         out_valid_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         a_re_q <= a_re_d;
         a_im_q <= a_im_d;
         b_re_q <= b_re_d;
         b_im_q <= b_im_d;
         acc_re_q <= acc_re_d;
         acc_im_q <= acc_im_d;
         out_valid_q <= out_valid_d;
         cnt_q <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_re = acc_re_q;
   assign out_im = acc_im_q;
   assign op_count = cnt_q;
endmodule

// File: tb/tb_crosscorr_cmul_seq.sv
// tb_crosscorr_cmul_seq: directed and random checks of both conjugate and plain variants
// against a 64-bit arithmetic reference
module tb_crosscorr_cmul_seq;
   import crosscorr_pkg::*;
   logic ap_clk = 1'b0, ap_rst = 1'b1;
   logic in_valid = 1'b0, out_ready = 1'b1;
   opnd_t a_re = '0, a_im = '0, b_re = '0, b_im = '0;
   logic in_ready, in_ready0, out_valid, out_valid0;
   res_t out_re, out_im, out_re0, out_im0;
   logic [15:0] op_count, op_count0;
   int checks = 0, failures = 0, cyc = 0;
   longint last_re, last_im;
   localparam opnd_t MINV = 25'sh1000000;
   localparam opnd_t MAXV = 25'sh0FFFFFF;

   always #5 ap_clk = ~ap_clk;
   always @(posedge ap_clk) cyc <= cyc + 1;

   crosscorr_cmul_seq #(.W_IN(W_IN), .W_OUT(W_OUT), .CONJ_B(1'b1)) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .out_valid(out_valid),
      .out_ready(out_ready), .out_re(out_re), .out_im(out_im), .op_count(op_count));

   crosscorr_cmul_seq #(.W_IN(W_IN), .W_OUT(W_OUT), .CONJ_B(1'b0)) dut0 (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready0),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .out_valid(out_valid0),
      .out_ready(out_ready), .out_re(out_re0), .out_im(out_im0), .op_count(op_count0));

   function automatic longint ref_re(longint ar, longint ai, longint br, longint bi, bit cj);
      return cj ? ar * br + ai * bi : ar * br - ai * bi;
   endfunction

   function automatic longint ref_im(longint ar, longint ai, longint br, longint bi, bit cj);
      return cj ? ai * br - ar * bi : ai * br + ar * bi;
   endfunction

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   // Presents one operand set, waits for the result and checks it; returns in OUT
   task automatic do_op(input opnd_t ar, input opnd_t ai, input opnd_t br, input opnd_t bi);
      int n;
      a_re = ar; a_im = ai; b_re = br; b_im = bi; in_valid = 1'b1;
      #1;
      chk("accept_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("accept_valid", out_valid, 0);
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      chk("latency", n, 4);
      chk("valid0", out_valid0, 1);
      last_re = ref_re(ar, ai, br, bi, 1'b1);
      last_im = ref_im(ar, ai, br, bi, 1'b1);
      chk("conj_re", out_re, last_re);
      chk("conj_im", out_im, last_im);
      chk("plain_re", out_re0, ref_re(ar, ai, br, bi, 1'b0));
      chk("plain_im", out_im0, ref_im(ar, ai, br, bi, 1'b0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int n, prev;
      logic [15:0] base;
      logic stale;
      repeat (2) tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_ready0", in_ready0, 1);
      chk("rst_re", out_re, 0);
      chk("rst_cnt", op_count, 0);
      @(negedge ap_clk) ap_rst = 1'b0;
      tick();
      do_op(25'sd3, 25'sd4, 25'sd1, 25'sd2);
      chk("basic_re", out_re, 11);
      chk("basic_im", out_im, -2);
      chk("basic_plain_re", out_re0, -5);
      chk("basic_plain_im", out_im0, 10);
      tick();
      chk("basic_cnt", op_count, 1);
      chk("basic_cnt0", op_count0, 1);
      chk("basic_idle", out_valid, 0);
      do_op(MINV, MINV, MINV, MINV);
      chk("ext_re", out_re, 64'sd1 <<< 49);
      chk("ext_im", out_im, 0);
      tick();
      do_op(MAXV, MINV, MINV, MAXV);
      tick();
      out_ready = 1'b0;
      do_op(25'($urandom), 25'($urandom), 25'($urandom), 25'($urandom));
      base = op_count;
      n = 0;
      repeat (10) begin
         tick();
         if (out_re !== res_t'(last_re) || out_im !== res_t'(last_im) || out_valid !== 1'b1 || in_ready !== 1'b0)
            n++;
      end
      chk("stall_hold", n, 0);
      chk("stall_cnt", op_count, base);
      out_ready = 1'b1;
      do_op(25'($urandom), 25'($urandom), 25'($urandom), 25'($urandom));
      chk("handoff_cnt", op_count, 16'(base + 16'd1));
      base = op_count;
      prev = cyc;
      for (int i = 0; i < 100; i++) begin
         do_op(25'($urandom), 25'($urandom), 25'($urandom), 25'($urandom));
         chk("b2b_interval", cyc - prev, 5);
         prev = cyc;
      end
      tick();
      chk("b2b_cnt", 16'(op_count - base), 101);
      a_re = 25'($urandom); a_im = 25'($urandom); b_re = 25'($urandom); b_im = 25'($urandom);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      #2 ap_rst = 1'b1;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_ready", in_ready, 1);
      chk("midrst_re", out_re, 0);
      chk("midrst_im", out_im, 0);
      chk("midrst_cnt", op_count, 0);
      @(negedge ap_clk) ap_rst = 1'b0;
      stale = 1'b0;
      repeat (6) begin
         tick();
         stale |= out_valid;
      end
      chk("no_stale", stale, 0);
      do_op(25'($urandom), 25'($urandom), 25'($urandom), 25'($urandom));
      tick();
      chk("post_rst_cnt", op_count, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/crosscorr_cmul_seq.md
# crosscorr_cmul_seq

Sequencer that time-shares one 25x25 signed multiplier to form a complex product for the cross-correlation datapath. It computes a·conj(b), or a·b when `CONJ_B` = 0, from 25-bit signed re/im operands. It runs four real multiplies over four cycles and accumulates them into 51-bit results. It sits between the FFT-bin fetch stage and the PHAT normalisation stage, with valid/ready handshakes on both sides.

## Interface
- `W_IN`, 25, operand width (signed)
- `W_OUT`, 51, result width (2·`W_IN`+1)
- `CONJ_B`, 1, 1 = a·conj(b); 0 = a·b

Ports:
- `ap_clk`  in  1  clock, rising edge
- `ap_rst`  in  1  reset; asynchronous, active-high
- `in_valid`  in  1  operand set valid
- `in_ready`  out  1  block accepts operands this cycle
- `a_re`, `a_im`, `b_re`, `b_im`  in  `W_IN` each  signed operands
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_re`, `out_im`  out  `W_OUT` each  signed result
- `op_count`  out  16  completed results delivered, wraps modulo 2^16

## Operation
- **FSM states:** `IDLE`, `M0`, `M1`, `M2`, `M3`, `OUT`.
- **Accept:** an accept occurs when `in_valid` && `in_ready` at a clock edge. The four operands are captured into registers, and the state goes to `M0`. The input buses are don't-care after the accept.
- **Multiply schedule.** One multiplier, one product per cycle, operands selected by state:
  - `M0`: `acc_re` ← `a_re`·`b_re`
  - `M1`: `acc_re` ← `acc_re` + s1·(`a_im`·`b_im`), where s1 = +1 if `CONJ_B`, else −1
  - `M2`: `acc_im` ← `a_im`·`b_re`
  - `M3`: `acc_im` ← `acc_im` + s2·(`a_re`·`b_im`), where s2 = −1 if `CONJ_B`, else +1
- **Width rules:**
  - Each product is sign-extended 2·`W_IN` = 50 bits.
  - Accumulation is sign-extended to `W_OUT`; no saturation and no rounding.
  - (−2^24)² + (−2^24)² = 2^49 fits in 51 bits, so overflow is impossible.
- **`OUT` state:**
  - `out_valid` = 1; `out_re`/`out_im` hold `acc_re`/`acc_im` stable until the handshake.
  - On `out_valid` && `out_ready`, `op_count` increments.
  - If `in_valid` is also high at that edge, the new set is accepted and the state goes to `M0`; otherwise it goes to `IDLE`.
- **`in_ready`:** equals 1 in `IDLE`, or in `OUT` when `out_ready` = 1 (combinational from `out_ready`). It is 0 in `M0`–`M3`.
- **Reset, anywhere including mid-`M*`:**
  - state → `IDLE`; `out_valid` = 0; `in_ready` = 1
  - `out_re` = `out_im` = 0; accumulators = 0; `op_count` = 0
  - The in-flight operation is discarded and no partial result is emitted.
- **Stall:** while in `OUT` with `out_ready` = 0, no state changes.

## Timing
- Accept at edge k → `M0` during cycle k..k+1 → `out_valid` = 1 after edge k+4.
- Latency is 4 cycles. Minimum initiation interval is 5 cycles, with back-to-back transfers via `OUT`→`M0`.
- All outputs are registered except `in_ready`.
- The multiplier is combinational: operands come from registers and the mux is selected by state, so the registered accumulator is the only pipeline stage.
- The multiplier is busy in exactly one operation per `M*` cycle. It is idle in `IDLE`/`OUT`, and its select is then held at `M0` operands to limit toggling.

## Structure
- **Shared package `crosscorr_pkg`:**
  - `W_IN` / `W_OUT` constants
  - state encoding enum (`IDLE`=0 … `OUT`=5, 3 bits)
  - signed operand/result typedefs
- **Sub-module `crosscorr_shared_mul`:** combinational signed `W_IN`×`W_IN`→2·`W_IN` multiplier, instantiated once.
- **Top level:** FSM, operand registers, operand mux, add/sub accumulator, counter.

## Test plan
- **Basic:** `CONJ_B`=1, a=(3,4), b=(1,2), `out_ready`=1 → `out_re`=11, `out_im`=−2, `out_valid` exactly 4 cycles after accept, `op_count`=1.
- **Plain multiply:** `CONJ_B`=0, same operands → `out_re`=−5, `out_im`=10.
- **Extremes:** `CONJ_B`=1, all operands −2^24 → `out_re`=2^49, `out_im`=0. With a=(2^24−1, −2^24), b=(−2^24, 2^24−1) → compare against a 64-bit reference model.
- **Backpressure and back-to-back:**
  - Hold `out_ready`=0 for 10 cycles → result stable, `in_ready`=0.
  - Release with `in_valid`=1 → same-edge handoff and accept; next result 4 cycles later.
  - 100 random back-to-back sets → interval 5 cycles, `op_count`=100.
- **Reset mid-op:** assert `ap_rst` asynchronously during `M2` → outputs zero immediately, `in_ready`=1. No stale `out_valid` after release; next operation correct.
- **`op_count` wrap:** 65536 completions → `op_count`=0.
